mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM).
- Fixed priority to DM so the MEM stage is not stalled, with a starvation guard for IF.
- Handles one outstanding transaction at a time, with variable memory latency and a response timeout.
- Sits between riscv_pipeline's instr/data interfaces and the unified memory model.

Parameters:
- DATA_WIDTH, 32, width of address and data buses
- MAX_WAIT, 4, number of consecutive lost arbitrations after which IF wins over DM
- TIMEOUT, 16, number of WAIT cycles without mem_rvalid before the transaction is aborted

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request; held until if_gnt
- if_addr  in  DATA_WIDTH  IF read address
- if_gnt  out  1  one-cycle pulse: IF request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_WIDTH  IF read data
- dm_req  in  1  DM request; held until dm_gnt
- dm_we  in  1  DM write enable (1 = write)
- dm_addr  in  DATA_WIDTH  DM address
- dm_wdata  in  DATA_WIDTH  DM write data
- dm_gnt  out  1  one-cycle pulse: DM request accepted
- dm_rvalid  out  1  one-cycle pulse: DM completion (read data valid, or write ack)
- dm_rdata  out  DATA_WIDTH  DM read data (0 for writes)
- mem_req  out  1  one-cycle memory command strobe
- mem_we  out  1  memory write enable, valid with mem_req
- mem_addr  out  DATA_WIDTH  memory address, held for the whole transaction
- mem_wdata  out  DATA_WIDTH  memory write data, held for the whole transaction
- mem_rvalid  in  1  memory completion, for both reads and writes
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; starve_cnt and wait_cnt go to 0.
  - Every output goes to 0.
  - Any in-flight transaction is dropped; no rvalid is ever issued for it.
- States: IDLE, WAIT.
- IDLE, on a clock edge with any req=1:
  - Choose the owner: DM if dm_req and !(if_req && starve_cnt>=MAX_WAIT); otherwise IF.
  - Latch owner, addr, and we (IF is always read). Latch wdata for DM writes, 0 otherwise.
  - Go to WAIT.
- First cycle in WAIT:
  - mem_req=1 and the owner's gnt=1, both for exactly this one cycle.
  - mem_addr, mem_we and mem_wdata are driven from the latched values and stay stable until the return to IDLE.
- In WAIT, req inputs are ignored. The requester must drop req in the gnt cycle; a req still high on return to IDLE is treated as a new request.
- WAIT, mem_rvalid sampled 1 (accepted in any WAIT cycle, including the mem_req cycle):
  - Go to IDLE.
  - Next cycle: the owner's rvalid=1 for one cycle, with rdata = registered mem_rdata (dm_rdata=0 for writes).
  - The non-owner's rvalid stays 0.
- WAIT, wait_cnt reaches TIMEOUT-1 with mem_rvalid=0:
  - Go to IDLE and set err=1.
  - The owner's rvalid pulses with rdata=0, so the pipeline never hangs.
- wait_cnt: cleared on entry to WAIT, incremented each WAIT cycle, saturating.
- mem_rvalid while IDLE is ignored (no rvalid pulse).
- starve_cnt:
  - Increments (saturating at MAX_WAIT) at each IDLE arbitration where if_req=1 and DM wins.
  - Clears when IF is granted, or when an IDLE cycle has if_req=0.
- Timing:
  - Minimum latency, req high at edge E to rvalid: gnt in cycle E+1, rvalid in cycle E+2 (zero-wait memory).
  - With back-to-back zero-wait transactions, throughput is one transaction per 2 cycles.
- mem_rvalid and reset asserted together: reset wins.

Test Plan:
- IF-only read, addr 0x10, memory returns 0xDEADBEEF 2 cycles after mem_req -> if_gnt pulse, mem_addr=0x10, mem_we=0, if_rvalid one cycle with 0xDEADBEEF, dm_rvalid stays 0.
- DM write, addr 0x100, wdata 0x1234, zero-wait memory -> dm_gnt and mem_req in the same cycle, mem_we=1, mem_wdata=0x1234, dm_rvalid next cycle, dm_rdata=0.
- if_req and dm_req both held continuously, MAX_WAIT=4 -> DM granted 4 times, then IF granted on the 5th arbitration, then DM again; the pattern repeats.
- Memory never asserts mem_rvalid, TIMEOUT=16 -> busy for 16 cycles, then owner rvalid with rdata=0, err=1 and stays 1 across later good transactions.
- Reset pulsed low during WAIT of a DM read -> all outputs 0 immediately; a later mem_rvalid produces no dm_rvalid; the next if_req is serviced normally.
- mem_rvalid pulsed while IDLE with no request -> no rvalid, no state change, busy=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for one single-port memory, DM priority with IF starvation guard
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  owner_dm_q, owner_dm_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  if_gnt_q, if_gnt_d;
  logic                  dm_gnt_q, dm_gnt_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  dm_rvalid_q, dm_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  err_q, err_d;
  logic                  dm_wins;
  logic [DATA_WIDTH-1:0] resp_data;

  always_comb begin
    state_d      = state_q;
    owner_dm_d   = owner_dm_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = 1'b0;
    if_gnt_d     = 1'b0;
    dm_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    dm_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    err_d        = err_q;
    resp_data    = '0;
    dm_wins      = dm_req && !(if_req && (starve_cnt_q >= SW'(MAX_WAIT)));

    case (state_q)
      S_IDLE: begin
        if (!if_req) starve_cnt_d = '0;
        if (if_req || dm_req) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
          mem_req_d  = 1'b1;
          if (dm_wins) begin
            owner_dm_d = 1'b1;
            addr_d     = dm_addr;
            we_d       = dm_we;
            wdata_d    = dm_we ? dm_wdata : '0;
            dm_gnt_d   = 1'b1;
            if (if_req && (starve_cnt_q < SW'(MAX_WAIT)))
              starve_cnt_d = starve_cnt_q + SW'(1);
          end else begin
            owner_dm_d   = 1'b0;
            addr_d       = if_addr;
            we_d         = 1'b0;
            wdata_d      = '0;
            if_gnt_d     = 1'b1;
            starve_cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_q < WW'(TIMEOUT - 1)) wait_cnt_d = wait_cnt_q + WW'(1);
        // Timeout completes with zero data so the pipeline always gets its rvalid.
        if (mem_rvalid || (wait_cnt_q == WW'(TIMEOUT - 1))) begin
          state_d = S_IDLE;
          if (mem_rvalid) resp_data = we_q ? '0 : mem_rdata;
          else            err_d     = 1'b1;
          if (owner_dm_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = resp_data;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = resp_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_dm_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      if_gnt_q     <= 1'b0;
      dm_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_dm_q   <= owner_dm_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      if_gnt_q     <= if_gnt_d;
      dm_gnt_q     <= dm_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      err_q        <= err_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_gnt    = dm_gnt_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == S_WAIT);
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_rvalid;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, busy, err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [135:0] all_outs;
  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  assign all_outs = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                     mem_req, mem_we, mem_addr, mem_wdata, busy, err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; mem_rvalid = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    step(); step();
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 32'h10;
    step();
    n_checks++;
    if ({if_gnt, dm_gnt, mem_req, mem_we, busy} !== 5'b10101) begin
      n_fail++; $display("FAIL if_gnt_cycle: got %b expected 10101", {if_gnt, dm_gnt, mem_req, mem_we, busy});
    end
    n_checks++;
    if (mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL if_mem_addr: got %h expected 00000010", mem_addr);
    end
    if_req = 0;
    step();
    n_checks++;
    if ({if_gnt, mem_req, busy, mem_addr} !== {3'b001, 32'h10}) begin
      n_fail++; $display("FAIL if_hold: got %b/%h expected 001/00000010", {if_gnt, mem_req, busy}, mem_addr);
    end
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rvalid = 0; mem_rdata = 32'h0;
    n_checks++;
    if ({if_rvalid, dm_rvalid, busy} !== 3'b100 || if_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL if_rvalid: got %b/%h expected 100/deadbeef", {if_rvalid, dm_rvalid, busy}, if_rdata);
    end
    step();
    n_checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL if_rvalid_pulse: got %b expected 00", {if_rvalid, dm_rvalid});
    end
  endtask

  task automatic test_dm_write();
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'h1234;
    step();
    n_checks++;
    if ({dm_gnt, if_gnt, mem_req, mem_we} !== 4'b1011 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234) begin
      n_fail++; $display("FAIL dm_write_gnt: got %b/%h/%h expected 1011/00000100/00001234",
                         {dm_gnt, if_gnt, mem_req, mem_we}, mem_addr, mem_wdata);
    end
    dm_req = 0; dm_we = 0;
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 0; mem_rdata = 0;
    n_checks++;
    if ({dm_rvalid, if_rvalid, busy} !== 3'b100 || dm_rdata !== 32'h0) begin
      n_fail++; $display("FAIL dm_write_ack: got %b/%h expected 100/00000000", {dm_rvalid, if_rvalid, busy}, dm_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g;
    logic [1:0] got_g;
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h30;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_g = ((i % 5) == 4) ? 2'b10 : 2'b01;
      got_g = {if_gnt, dm_gnt};
      n_checks++;
      if (got_g !== exp_g) begin
        n_fail++; $display("FAIL starve_grant_%0d: got if/dm %b expected %b", i, got_g, exp_g);
      end
      mem_rvalid = 1; mem_rdata = 32'h100 + i;
      step();
      mem_rvalid = 0;
    end
    if_req = 0; dm_req = 0;
    step();
  endtask

  task automatic test_timeout();
    int busy_cycles;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_before_timeout: got %b expected 0", err);
    end
    dm_req = 1; dm_we = 0; dm_addr = 32'h40; mem_rdata = 32'h55;
    step();
    dm_req = 0;
    busy_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy === 1'b1) busy_cycles++;
      step();
    end
    n_checks++;
    if (busy_cycles != 16) begin
      n_fail++; $display("FAIL timeout_busy_cycles: got %0d expected 16", busy_cycles);
    end
    n_checks++;
    if ({busy, dm_rvalid, if_rvalid, err} !== 4'b0101 || dm_rdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout_resp: got %b/%h expected 0101/00000000", {busy, dm_rvalid, if_rvalid, err}, dm_rdata);
    end
    step();
    if_req = 1; if_addr = 32'h50;
    step();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5;
    step();
    mem_rvalid = 0;
    n_checks++;
    if ({if_rvalid, err} !== 2'b11 || if_rdata !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL err_sticky: got %b/%h expected 11/a5a5a5a5", {if_rvalid, err}, if_rdata);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    step();
    dm_req = 0;
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_in_wait_outs: got %h expected 0", all_outs);
    end
    step();
    reset = 1'b1;
    mem_rvalid = 1; mem_rdata = 32'h77;
    step();
    mem_rvalid = 0;
    n_checks++;
    if ({dm_rvalid, if_rvalid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_drops_txn: got %b expected 000", {dm_rvalid, if_rvalid, busy});
    end
    if_req = 1; if_addr = 32'h300;
    step();
    if_req = 0;
    n_checks++;
    if ({if_gnt, mem_req} !== 2'b11 || mem_addr !== 32'h300) begin
      n_fail++; $display("FAIL post_reset_gnt: got %b/%h expected 11/00000300", {if_gnt, mem_req}, mem_addr);
    end
    mem_rvalid = 1; mem_rdata = 32'hCAFE;
    step();
    mem_rvalid = 0;
    n_checks++;
    if ({if_rvalid, err} !== 2'b10 || if_rdata !== 32'hCAFE) begin
      n_fail++; $display("FAIL post_reset_rvalid: got %b/%h expected 10/0000cafe", {if_rvalid, err}, if_rdata);
    end
    step();
  endtask

  task automatic test_idle_rvalid();
    mem_rvalid = 1; mem_rdata = 32'h99;
    step();
    mem_rvalid = 0;
    n_checks++;
    if ({if_rvalid, dm_rvalid, busy, mem_req, if_gnt, dm_gnt} !== 6'b0) begin
      n_fail++; $display("FAIL idle_rvalid: got %b expected 000000", {if_rvalid, dm_rvalid, busy, mem_req, if_gnt, dm_gnt});
    end
    step();
    n_checks++;
    if ({if_rvalid, dm_rvalid, busy} !== 3'b0) begin
      n_fail++; $display("FAIL idle_rvalid_after: got %b expected 000", {if_rvalid, dm_rvalid, busy});
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_write();
    test_starvation();
    test_timeout();
    test_reset_in_wait();
    test_idle_rvalid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
